m68k_dtack: RTL and testbench

M68K_DTACK -- requirements
Module: m68k_dtack

---
 rtl/m68k_dtack_pkg.sv | 27 ++
 rtl/shared_ram_arb.sv | 31 +++
 rtl/m68k_dtack.sv | 183 ++++++++++++++++++
 tb/tb_m68k_dtack.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_dtack_pkg.sv
// Shared system package: bus-cycle FSM encoding and default wait/timeout constants
// used by the 68K DTACK generator and the board top level.
package m68k_dtack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROM     = 3'd1,
        ST_SHR_ARB = 3'd2,
        ST_COUNT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_HOLD    = 3'd5
    } dtack_state_e;

    localparam int DEF_RAM_WAIT = 0;
    localparam int DEF_IO_WAIT  = 1;
    localparam int DEF_SHR_WAIT = 1;
    localparam int DEF_TIMEOUT  = 255;

    localparam int WAIT_W    = 4;
    localparam int TIMEOUT_W = 8;

    // Wait counts above the 4-bit counter range saturate instead of wrapping.
    function automatic logic [WAIT_W-1:0] wait_load(input int w);
        return (w > 15) ? 4'd15 : WAIT_W'(w);
    endfunction

endpackage

// File: rtl/shared_ram_arb.sv
// Shared-RAM ownership between the 68K and the Z80. The Z80 keeps the RAM whenever
// its request is high at the moment the 68K asks, so a simultaneous request goes to it.
module shared_ram_arb (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic cpu_req,
    input  logic cpu_done,
    input  logic z80_shr_req,
    output logic grant,
    output logic shr_owner,
    output logic z80_wait_n
);

    assign grant = cpu_req && clk_en && !z80_shr_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            shr_owner  <= 1'b0;
            z80_wait_n <= 1'b1;
        end else begin
            // Registered from the current owner, so WAIT releases one clk after ownership drops.
            z80_wait_n <= !(shr_owner && z80_shr_req);
            if (cpu_done)
                shr_owner <= 1'b0;
            else if (grant)
                shr_owner <= 1'b1;
        end
    end

endmodule

// File: rtl/m68k_dtack.sv
// 68K DTACK generator: routes each bus cycle by region select, applies per-region
// wait states, ROM fetch handshake, shared-RAM arbitration and a bus timeout.
module m68k_dtack
    import m68k_dtack_pkg::*;
#(
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int SHR_WAIT = DEF_SHR_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic cpu_as_n,
    input  logic prog_rom_cs,
    input  logic ram_cs,
    input  logic sprite_ram_cs,
    input  logic shared_ram_cs,
    input  logic io_cs,
    input  logic rom_ok,
    input  logic z80_shr_req,
    output logic cpu_dtack_n,
    output logic rom_req,
    output logic shr_owner,
    output logic z80_wait_n,
    output logic bus_timeout
);

    localparam logic [WAIT_W-1:0]    RAM_W   = wait_load(RAM_WAIT);
    localparam logic [WAIT_W-1:0]    IO_W    = wait_load(IO_WAIT);
    localparam logic [WAIT_W-1:0]    SHR_W   = wait_load(SHR_WAIT);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    dtack_state_e          state, state_nx;
    logic [WAIT_W-1:0]     wcnt, wcnt_nx;
    logic [TIMEOUT_W-1:0]  tcnt, tcnt_nx;
    logic                  armed, armed_nx;
    logic                  got_ok, got_ok_nx;
    logic                  dtack_n_nx, rom_req_nx, timeout_nx;
    logic                  to_hit, shr_req, shr_done, shr_grant;

    // AS/DTACK handshake: a cycle is taken once per AS-low period (AS must first be seen
    // high on a clk_en); DTACK then stays low until AS rises, and AS rising before DTACK
    // abandons the cycle without acknowledging it.
    assign to_hit   = clk_en && (tcnt == TO_LAST);
    assign shr_req  = (state == ST_SHR_ARB) && !cpu_as_n && !to_hit;
    assign shr_done = (state != ST_IDLE) && cpu_as_n;

    shared_ram_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .cpu_req     (shr_req),
        .cpu_done    (shr_done),
        .z80_shr_req (z80_shr_req),
        .grant       (shr_grant),
        .shr_owner   (shr_owner),
        .z80_wait_n  (z80_wait_n)
    );

    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        tcnt_nx    = tcnt;
        got_ok_nx  = got_ok;
        armed_nx   = armed | (clk_en & cpu_as_n);
        dtack_n_nx = cpu_dtack_n;
        rom_req_nx = rom_req;
        timeout_nx = 1'b0;
        if (state != ST_IDLE && state != ST_HOLD && cpu_as_n) begin
            state_nx   = ST_IDLE;
            dtack_n_nx = 1'b1;
            rom_req_nx = 1'b0;
            wcnt_nx    = '0;
            tcnt_nx    = '0;
            got_ok_nx  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clk_en && !cpu_as_n && armed) begin
                        armed_nx  = 1'b0;
                        tcnt_nx   = '0;
                        got_ok_nx = 1'b0;
                        if (prog_rom_cs) begin
                            state_nx   = ST_ROM;
                            rom_req_nx = 1'b1;
                        end else if (shared_ram_cs) begin
                            state_nx = ST_SHR_ARB;
                        end else begin
                            state_nx = ST_COUNT;
                            if (ram_cs || sprite_ram_cs) wcnt_nx = RAM_W;
                            else if (io_cs)              wcnt_nx = IO_W;
                            else                         wcnt_nx = '0;
                        end
                    end
                end
                ST_ROM: begin
                    // rom_ok may be a single-clk pulse between clk_en strobes; remember it.
                    if (rom_ok) begin
                        rom_req_nx = 1'b0;
                        got_ok_nx  = 1'b1;
                    end
                    if (clk_en) begin
                        if (rom_ok || got_ok) begin
                            state_nx   = ST_ACK;
                            dtack_n_nx = 1'b0;
                        end else if (to_hit) begin
                            state_nx   = ST_ACK;
                            dtack_n_nx = 1'b0;
                            rom_req_nx = 1'b0;
                            timeout_nx = 1'b1;
                        end else begin
                            tcnt_nx = tcnt + 8'd1;
                        end
                    end
                end
                ST_SHR_ARB: begin
                    if (clk_en) begin
                        if (to_hit) begin
                            state_nx   = ST_ACK;
                            dtack_n_nx = 1'b0;
                            timeout_nx = 1'b1;
                        end else begin
                            tcnt_nx = tcnt + 8'd1;
                            if (shr_grant) begin
                                state_nx = ST_COUNT;
                                wcnt_nx  = SHR_W;
                            end
                        end
                    end
                end
                ST_COUNT: begin
                    if (clk_en) begin
                        if (wcnt == '0) begin
                            state_nx   = ST_ACK;
                            dtack_n_nx = 1'b0;
                        end else if (to_hit) begin
                            state_nx   = ST_ACK;
                            dtack_n_nx = 1'b0;
                            timeout_nx = 1'b1;
                        end else begin
                            wcnt_nx = wcnt - 4'd1;
                            tcnt_nx = tcnt + 8'd1;
                        end
                    end
                end
                ST_ACK: state_nx = ST_HOLD;
                ST_HOLD: begin
                    if (cpu_as_n) begin
                        state_nx   = ST_IDLE;
                        dtack_n_nx = 1'b1;
                        wcnt_nx    = '0;
                        tcnt_nx    = '0;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wcnt        <= '0;
            tcnt        <= '0;
            armed       <= 1'b0;
            got_ok      <= 1'b0;
            cpu_dtack_n <= 1'b1;
            rom_req     <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            tcnt        <= tcnt_nx;
            armed       <= armed_nx;
            got_ok      <= got_ok_nx;
            cpu_dtack_n <= dtack_n_nx;
            rom_req     <= rom_req_nx;
            bus_timeout <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_m68k_dtack.sv
// Bench for m68k_dtack: a transaction-level model predicts every output each clk;
// directed scenarios pin the model with hand-computed latencies.
module tb_m68k_dtack;

    localparam int RAM_WAIT = 0;
    localparam int IO_WAIT  = 1;
    localparam int SHR_WAIT = 1;
    localparam int TIMEOUT  = 255;
    localparam int K_ROM = 0, K_SHR = 1, K_FIXED = 2;

    logic clk, reset, clk_en, cpu_as_n;
    logic prog_rom_cs, ram_cs, sprite_ram_cs, shared_ram_cs, io_cs, rom_ok, z80_shr_req;
    logic cpu_dtack_n, rom_req, shr_owner, z80_wait_n, bus_timeout;

    int errors = 0;
    int checks = 0;
    bit rand_en = 0;
    logic [4:0] exp_q[$];
    logic [4:0] cmp_exp, cmp_act;

    m68k_dtack #(
        .RAM_WAIT (RAM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .SHR_WAIT (SHR_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .cpu_as_n      (cpu_as_n),
        .prog_rom_cs   (prog_rom_cs),
        .ram_cs        (ram_cs),
        .sprite_ram_cs (sprite_ram_cs),
        .shared_ram_cs (shared_ram_cs),
        .io_cs         (io_cs),
        .rom_ok        (rom_ok),
        .z80_shr_req   (z80_shr_req),
        .cpu_dtack_n   (cpu_dtack_n),
        .rom_req       (rom_req),
        .shr_owner     (shr_owner),
        .z80_wait_n    (z80_wait_n),
        .bus_timeout   (bus_timeout)
    );

    // ---------------- clock / reset / clk_en ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) clk_en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;

    // ---------------- behavioural model ----------------
    bit   m_busy, m_acked, m_armed, m_rom_done;
    int   m_kind, m_left, m_elapsed;
    logic m_dtack_n = 1'b1, m_rom_req = 1'b0, m_owner = 1'b0, m_wait_n = 1'b1, m_bto = 1'b0;

    always @(posedge clk) begin : model
        logic own_q;
        own_q = m_owner;
        m_bto = 1'b0;
        if (reset) begin
            m_busy = 0; m_acked = 0; m_armed = 0;
            m_dtack_n = 1'b1; m_rom_req = 1'b0; m_owner = 1'b0; m_wait_n = 1'b1;
        end else begin
            m_wait_n = !(own_q && z80_shr_req);
            if (m_acked) begin
                if (cpu_as_n) begin
                    m_acked = 0; m_dtack_n = 1'b1; m_owner = 1'b0;
                end
            end else if (m_busy) begin
                if (cpu_as_n) begin
                    m_busy = 0; m_dtack_n = 1'b1; m_rom_req = 1'b0; m_owner = 1'b0;
                end else begin
                    if (m_kind == K_ROM && rom_ok) begin
                        m_rom_done = 1; m_rom_req = 1'b0;
                    end
                    if (clk_en) begin
                        if ((m_kind == K_ROM && m_rom_done) || (m_kind == K_FIXED && m_left == 0)) begin
                            m_busy = 0; m_acked = 1; m_dtack_n = 1'b0;
                        end else if (m_elapsed == TIMEOUT - 1) begin
                            m_busy = 0; m_acked = 1; m_dtack_n = 1'b0; m_bto = 1'b1; m_rom_req = 1'b0;
                        end else begin
                            m_elapsed++;
                            if (m_kind == K_SHR && !z80_shr_req) begin
                                m_owner = 1'b1; m_kind = K_FIXED; m_left = SHR_WAIT;
                            end else if (m_kind == K_FIXED) begin
                                m_left--;
                            end
                        end
                    end
                end
            end else if (clk_en && !cpu_as_n && m_armed) begin
                m_armed = 0; m_busy = 1; m_elapsed = 0; m_rom_done = 0;
                if (prog_rom_cs) begin
                    m_kind = K_ROM; m_rom_req = 1'b1;
                end else if (shared_ram_cs) begin
                    m_kind = K_SHR;
                end else begin
                    m_kind = K_FIXED;
                    m_left = (ram_cs || sprite_ram_cs) ? RAM_WAIT : (io_cs ? IO_WAIT : 0);
                end
            end
            if (clk_en && cpu_as_n) m_armed = 1;
        end
        exp_q.push_back({m_dtack_n, m_rom_req, m_owner, m_wait_n, m_bto});
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            cmp_act = {cpu_dtack_n, rom_req, shr_owner, z80_wait_n, bus_timeout};
            checks++;
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL outputs t=%0t {dtack_n,rom_req,owner,wait_n,timeout} got %b expected %b",
                         $time, cmp_act, cmp_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic bus_idle();
        cpu_as_n = 1'b1; prog_rom_cs = 1'b0; ram_cs = 1'b0; sprite_ram_cs = 1'b0;
        shared_ram_cs = 1'b0; io_cs = 1'b0; rom_ok = 1'b0;
    endtask

    task automatic wait_armed();
        int k = 0;
        while (!m_armed && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!m_armed) check("arm_wait_expired", 0, 1);
    endtask

    task automatic random_txn();
        int sel, abort_at, ok_at, hold, k;
        bit done;
        wait_armed();
        sel = $urandom_range(0, 31) & $urandom_range(0, 31);
        {prog_rom_cs, shared_ram_cs, ram_cs, sprite_ram_cs, io_cs} = 5'(sel);
        abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
        ok_at    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
        hold     = $urandom_range(0, 3);
        cpu_as_n = 1'b0;
        done = 0;
        k = 0;
        while (!done && k < 1200) begin
            @(negedge clk);
            k++;
            rom_ok = (ok_at != 0) && (k == ok_at);
            if ($urandom_range(0, 3) == 0) z80_shr_req = ~z80_shr_req;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                done = 1;
            end else if (abort_at != 0 && k == abort_at) begin
                done = 1;
            end else if (!m_dtack_n) begin
                repeat (hold) begin
                    @(negedge clk);
                    if ($urandom_range(0, 3) == 0) z80_shr_req = ~z80_shr_req;
                end
                done = 1;
            end
        end
        if (!done) check("txn_dtack_wait_expired", 0, 1);
        bus_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int first, first2, hi, pulses, own_first, w3, w10, w13, w14, own2, saw, bto_dt, bto_rr, rr3, rr4;
        clk_en = 1'b1;
        reset = 1'b1;
        z80_shr_req = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        check("reset_dtack_n", cpu_dtack_n, 1);
        check("reset_rom_req", rom_req, 0);
        check("reset_owner", shr_owner, 0);
        check("reset_wait_n", z80_wait_n, 1);
        check("reset_timeout", bus_timeout, 0);
        reset = 1'b0;

        // ram_cs, zero wait: DTACK on the 2nd clk_en, released 1 clk after AS rises
        wait_armed();
        ram_cs = 1'b1; cpu_as_n = 1'b0; first = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (first < 0 && !cpu_dtack_n) first = i;
        end
        check("ram_dtack_latency", first, 2);
        bus_idle();
        @(negedge clk);
        check("ram_dtack_release", cpu_dtack_n, 1);

        // ROM with rom_ok arriving so that rom_req is high 7 clk
        wait_armed();
        prog_rom_cs = 1'b1; cpu_as_n = 1'b0; first = -1; hi = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rom_req) hi++;
            if (first < 0 && !cpu_dtack_n) first = i;
            rom_ok = (i == 7);
        end
        check("rom_req_high_clks", hi, 7);
        check("rom_dtack_index", first, 8);
        bus_idle();

        // shared RAM blocked by Z80 for 5 clk, then granted; later Z80 request stalls
        wait_armed();
        shared_ram_cs = 1'b1; cpu_as_n = 1'b0; z80_shr_req = 1'b1;
        own_first = -1; first = -1; w3 = -1; w10 = -1; w13 = -1; w14 = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (own_first < 0 && shr_owner) own_first = i;
            if (first < 0 && !cpu_dtack_n) first = i;
            if (i == 3)  w3  = int'(z80_wait_n);
            if (i == 10) w10 = int'(z80_wait_n);
            if (i == 13) w13 = int'(z80_wait_n);
            if (i == 14) w14 = int'(z80_wait_n);
            if (i == 5)  z80_shr_req = 1'b0;
            if (i == 9)  z80_shr_req = 1'b1;
            if (i == 12) cpu_as_n = 1'b1;
        end
        check("shr_grant_index", own_first, 6);
        check("shr_dtack_index", first, 8);
        check("shr_z80_unstalled_while_arb", w3, 1);
        check("shr_z80_wait_while_owned", w10, 0);
        check("shr_z80_wait_at_release", w13, 0);
        check("shr_z80_wait_after_release", w14, 1);
        z80_shr_req = 1'b0;
        bus_idle();

        // ROM never answers: timeout on the 255th clk_en in the wait state
        wait_armed();
        prog_rom_cs = 1'b1; cpu_as_n = 1'b0; pulses = 0; first = -1; bto_dt = -1; bto_rr = -1;
        for (int i = 1; i <= 270; i++) begin
            @(negedge clk);
            if (bus_timeout) begin
                pulses++;
                if (first < 0) begin
                    first = i; bto_dt = int'(cpu_dtack_n); bto_rr = int'(rom_req);
                end
            end
        end
        check("timeout_index", first, 256);
        check("timeout_pulses", pulses, 1);
        check("timeout_dtack_n", bto_dt, 0);
        check("timeout_rom_req", bto_rr, 0);
        bus_idle();

        // AS released mid-ROM wait, then a normal cycle
        wait_armed();
        prog_rom_cs = 1'b1; cpu_as_n = 1'b0; saw = 0; rr3 = -1; rr4 = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!cpu_dtack_n) saw = 1;
            if (i == 3) begin
                rr3 = int'(rom_req);
                cpu_as_n = 1'b1; prog_rom_cs = 1'b0;
            end
            if (i == 4) rr4 = int'(rom_req);
        end
        check("abort_rom_req_before", rr3, 1);
        check("abort_rom_req_after", rr4, 0);
        check("abort_no_dtack", saw, 0);
        wait_armed();
        io_cs = 1'b1; cpu_as_n = 1'b0; first2 = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (first2 < 0 && !cpu_dtack_n) first2 = i;
        end
        check("post_abort_io_dtack_index", first2, 3);
        bus_idle();

        // reset during COUNT after a shared-RAM grant
        wait_armed();
        shared_ram_cs = 1'b1; cpu_as_n = 1'b0; own2 = -1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            if (i == 2) own2 = int'(shr_owner);
        end
        check("rst_count_owner_before", own2, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_count_dtack_n", cpu_dtack_n, 1);
        check("rst_count_owner", shr_owner, 0);
        check("rst_count_rom_req", rom_req, 0);
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (!cpu_dtack_n) saw = 1;
        end
        check("rst_count_no_dtack", saw, 0);
        bus_idle();

        // randomized traffic with random clk_en
        rand_en = 1;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
            random_txn();
        end
        rand_en = 0;
        z80_shr_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
